hevc_dequant_stream: RTL and testbench



---
 rtl/hevc_dequant_stream.sv | 265 ++++++++++++++++++++++++++
 tb/tb_hevc_dequant_stream.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hevc_dequant_stream.sv
// hevc_dequant_stream
// Streaming HEVC inverse quantizer with a flat scaling list (m = 16).
// A transform unit's configuration is loaded through the cfg handshake.
// Its levels then stream through a three-stage pipeline:
//   S1 multiplies the level by the scale.
//   S2 applies the per shift and adds the rounding offset.
//   S3 performs the bdShift arithmetic shift and clips to COEF_W bits.
// Scale, per, bdShift and the last flag ride along with every beat.
// Consecutive TUs with different configurations therefore never mix.

module hevc_dequant_stream #(
    parameter int LVL_W  = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [3:0]               cfg_per,
    input  logic [2:0]               cfg_rem,
    input  logic [2:0]               cfg_log2_size,
    input  logic [3:0]               cfg_bit_depth,
    output logic                     cfg_err,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [LVL_W-1:0]  in_level,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [COEF_W-1:0] out_coef,
    output logic                     out_last
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Clip bounds, sign-extended to the accumulator width.
    localparam logic signed [ACC_W-1:0] COEF_MAX =
        {{(ACC_W-COEF_W+1){1'b0}}, {(COEF_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] COEF_MIN =
        {{(ACC_W-COEF_W+1){1'b1}}, {(COEF_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_ONE =
        {{(ACC_W-1){1'b0}}, 1'b1};

    // 16 * levelScale[rem], where levelScale = {40, 45, 51, 57, 64, 72}.
    function automatic logic [10:0] flat_scale(input logic [2:0] rem);
        logic [10:0] s;
        case (rem)
            3'd0:    s = 11'd640;
            3'd1:    s = 11'd720;
            3'd2:    s = 11'd816;
            3'd3:    s = 11'd912;
            3'd4:    s = 11'd1024;
            3'd5:    s = 11'd1152;
            default: s = 11'd0;
        endcase
        return s;
    endfunction

    // A configuration is legal only if every field lies inside its range.
    function automatic logic cfg_legal(input logic [3:0] per,
                                       input logic [2:0] rem,
                                       input logic [2:0] log2_size,
                                       input logic [3:0] bit_depth);
        logic ok;
        ok = (rem <= 3'd5) &&
             (log2_size >= 3'd2) && (log2_size <= 3'd5) &&
             (per <= 4'd10) &&
             (bit_depth >= 4'd8) && (bit_depth <= 4'd12);
        return ok;
    endfunction

    // Saturate the shifted accumulator into the signed COEF_W range.
    function automatic logic signed [COEF_W-1:0] clip_coef(
        input logic signed [ACC_W-1:0] r);
        logic signed [COEF_W-1:0] c;
        if (r > COEF_MAX) begin
            c = COEF_MAX[COEF_W-1:0];
        end else if (r < COEF_MIN) begin
            c = COEF_MIN[COEF_W-1:0];
        end else begin
            c = r[COEF_W-1:0];
        end
        return c;
    endfunction

    // Control state and latched per-TU configuration.
    state_t      state_r;
    state_t      state_nxt_s;
    logic [9:0]  cnt_r;
    logic [3:0]  per_r;
    logic [10:0] scale_r;
    logic [3:0]  bds_r;
    logic [2:0]  log2_r;

    // Pipeline registers.
    logic                    v1_r;
    logic signed [ACC_W-1:0] p1_r;
    logic [3:0]              per1_r;
    logic [3:0]              bds1_r;
    logic                    last1_r;
    logic                    v2_r;
    logic signed [ACC_W-1:0] q2_r;
    logic [3:0]              bds2_r;
    logic                    last2_r;

    // Combinational helpers.
    logic                    legal_s;
    logic                    cfg_fire_s;
    logic                    in_fire_s;
    logic                    adv1_s;
    logic                    adv2_s;
    logic                    adv3_s;
    logic [9:0]              last_idx_s;
    logic                    is_last_s;
    logic [3:0]              bds_new_s;
    logic signed [ACC_W-1:0] lvl_ext_s;
    logic signed [ACC_W-1:0] scale_ext_s;
    logic signed [ACC_W-1:0] p_s;
    logic signed [ACC_W-1:0] q_s;
    logic signed [ACC_W-1:0] r_s;

    assign legal_s    = cfg_legal(cfg_per, cfg_rem, cfg_log2_size, cfg_bit_depth);
    assign cfg_ready  = (state_r == IDLE);
    assign cfg_fire_s = cfg_valid & cfg_ready & legal_s;
    assign bds_new_s  = cfg_bit_depth + {1'b0, cfg_log2_size} - 4'd5;

    // Each stage moves when its successor is empty or is itself moving.
    assign adv3_s    = ~out_valid | out_ready;
    assign adv2_s    = ~v2_r | adv3_s;
    assign adv1_s    = ~v1_r | adv2_s;
    assign in_ready  = (state_r == RUN) & adv1_s;
    assign in_fire_s = in_valid & in_ready;

    // The final beat index is (1 << 2*log2_size) - 1, with at most 1024 beats.
    assign last_idx_s = 10'((11'd1 << {log2_r, 1'b0}) - 11'd1);
    assign is_last_s  = (cnt_r == last_idx_s);

    // Datapath: the level is sign-extended and the scale zero-extended.
    assign lvl_ext_s   = {{(ACC_W-LVL_W){in_level[LVL_W-1]}}, in_level};
    assign scale_ext_s = {{(ACC_W-11){1'b0}}, scale_r};
    assign p_s         = lvl_ext_s * scale_ext_s;
    assign q_s         = (p1_r <<< per1_r) + (ACC_ONE <<< (bds1_r - 4'd1));
    assign r_s         = q2_r >>> bds2_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic: load a legal config, leave RUN on the last beat.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (cfg_fire_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (in_fire_s && is_last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Latch the per-TU configuration on a legal config handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_r   <= 4'd0;
            scale_r <= 11'd0;
            bds_r   <= 4'd0;
            log2_r  <= 3'd0;
        end else if (cfg_fire_s) begin
            per_r   <= cfg_per;
            scale_r <= flat_scale(cfg_rem);
            bds_r   <= bds_new_s;
            log2_r  <= cfg_log2_size;
        end
    end

    // Beat counter: cleared on config load, stepped on each accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 10'd0;
        end else if (cfg_fire_s) begin
            cnt_r <= 10'd0;
        end else if (in_fire_s) begin
            cnt_r <= cnt_r + 10'd1;
        end
    end

    // One-cycle error pulse in the cycle after a rejected config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_valid & cfg_ready & ~legal_s;
        end
    end

    // Stage 1: multiply the level by the scale and capture the sideband.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r    <= 1'b0;
            p1_r    <= '0;
            per1_r  <= 4'd0;
            bds1_r  <= 4'd0;
            last1_r <= 1'b0;
        end else if (adv1_s) begin
            v1_r <= in_fire_s;
            if (in_fire_s) begin
                p1_r    <= p_s;
                per1_r  <= per_r;
                bds1_r  <= bds_r;
                last1_r <= is_last_s;
            end
        end
    end

    // Stage 2: apply the per shift and add the rounding offset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r    <= 1'b0;
            q2_r    <= '0;
            bds2_r  <= 4'd0;
            last2_r <= 1'b0;
        end else if (adv2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                q2_r    <= q_s;
                bds2_r  <= bds1_r;
                last2_r <= last1_r;
            end
        end
    end

    // Stage 3: arithmetic shift and clip; hold steady while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_coef  <= '0;
            out_last  <= 1'b0;
        end else if (adv3_s) begin
            out_valid <= v2_r;
            if (v2_r) begin
                out_coef <= clip_coef(r_s);
                out_last <= last2_r;
            end
        end
    end

endmodule

// File: tb/tb_hevc_dequant_stream.sv
// Self-checking bench for hevc_dequant_stream.
// A table of TU vectors is run through the block. Each vector alternates two
// levels whose expected coefficients were worked out by hand. Short directed
// sequences then cover rejected configs, the back-pressure fill and a reset
// issued in the middle of a TU.

module tb_hevc_dequant_stream;

    logic               clk;
    logic               rst_n;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [3:0]         cfg_per;
    logic [2:0]         cfg_rem;
    logic [2:0]         cfg_log2_size;
    logic [3:0]         cfg_bit_depth;
    logic               cfg_err;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_level;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_coef;
    logic               out_last;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int bd;
        int lg;
        int per;
        int rem;
        int lvl_a;
        int lvl_b;
        int exp_a;
        int exp_b;
        bit bp;
    } vec_t;

    vec_t tbl[9];

    hevc_dequant_stream #(.LVL_W(16), .COEF_W(16), .ACC_W(40)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_per       (cfg_per),
        .cfg_rem       (cfg_rem),
        .cfg_log2_size (cfg_log2_size),
        .cfg_bit_depth (cfg_bit_depth),
        .cfg_err       (cfg_err),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_level      (in_level),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_coef      (out_coef),
        .out_last      (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Present one config for one cycle, then check the handshake response.
    task automatic do_cfg(input int bd, input int lg, input int pr, input int rm,
                          input bit legal);
        @(negedge clk);
        cfg_bit_depth = 4'(bd);
        cfg_log2_size = 3'(lg);
        cfg_per       = 4'(pr);
        cfg_rem       = 3'(rm);
        cfg_valid     = 1'b1;
        #1;
        check("cfg_ready_before", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        check("cfg_err", cfg_err, legal ? 0 : 1);
        check("cfg_ready_after", cfg_ready, legal ? 0 : 1);
        if (!legal) begin
            check("in_ready_idle", in_ready, 0);
            @(negedge clk);
            #1;
            check("cfg_err_pulse_end", cfg_err, 0);
        end
    endtask

    // Configure, stream a whole TU and check every output beat.
    task automatic run_tu(input vec_t v);
        int n;
        int sent;
        int got;
        int iter;
        int first_acc;
        int first_out;
        int last_acc_iter;
        int exp_v;
        bit stalled;
        logic signed [15:0] held_coef;
        logic held_last;
        n = 1 << (2 * v.lg);
        sent = 0;
        got = 0;
        iter = 0;
        first_acc = -1;
        first_out = -1;
        last_acc_iter = -1;
        stalled = 1'b0;
        held_coef = '0;
        held_last = 1'b0;
        do_cfg(v.bd, v.lg, v.per, v.rem, 1'b1);
        while (got < n && iter < 20000) begin
            @(negedge clk);
            if (v.bp) begin
                out_ready = (iter < 6) ? 1'b0 : 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
            if (sent < n) begin
                in_valid = 1'b1;
                in_level = (sent % 2 == 0) ? 16'(v.lvl_a) : 16'(v.lvl_b);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stalled) begin
                check("hold_valid", out_valid, 1);
                check("hold_coef", out_coef, held_coef);
                check("hold_last", out_last, held_last);
            end
            if (last_acc_iter >= 0 && last_acc_iter == iter - 1) begin
                check("cfg_ready_after_last", cfg_ready, 1);
                check("in_ready_after_last", in_ready, 0);
            end
            if (v.bp && iter == 5) begin
                check("bp_in_ready_low", in_ready, 0);
                check("bp_accepted", sent, 3);
            end
            if (out_valid && out_ready) begin
                exp_v = (got % 2 == 0) ? v.exp_a : v.exp_b;
                check("coef", out_coef, exp_v);
                check("last", out_last, (got == n - 1) ? 1 : 0);
                if (first_out < 0) first_out = iter;
                got++;
            end
            stalled   = out_valid && !out_ready;
            held_coef = out_coef;
            held_last = out_last;
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = iter;
                if (sent == n - 1) begin
                    last_acc_iter = iter;
                    check("cfg_ready_on_last", cfg_ready, 0);
                end
                sent++;
            end
            iter++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("beats_out", got, n);
        if (!v.bp) check("latency", first_out - first_acc, 3);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("no_extra_beat", out_valid, 0);
        end
    endtask

    initial begin
        tbl[0] = '{8, 2, 4, 1, 1, -1, 360, -360, 1'b0};
        tbl[1] = '{8, 2, 0, 0, 3, 3, 60, 60, 1'b0};
        tbl[2] = '{8, 2, 8, 3, 32767, -32768, 32767, -32768, 1'b0};
        tbl[3] = '{12, 2, 0, 5, 100, -7, 225, -16, 1'b0};
        tbl[4] = '{8, 2, 2, 0, -7, 0, -560, 0, 1'b0};
        tbl[5] = '{8, 3, 10, 2, 1, 1, 13056, 13056, 1'b0};
        tbl[6] = '{10, 5, 6, 4, 2, 2, 128, 128, 1'b0};
        tbl[7] = '{8, 2, 4, 1, 1, -1, 360, -360, 1'b1};
        tbl[8] = '{9, 4, 1, 3, 5, -5, 36, -36, 1'b0};

        rst_n = 1'b0;
        cfg_valid = 1'b0;
        cfg_per = 4'd0;
        cfg_rem = 3'd0;
        cfg_log2_size = 3'd0;
        cfg_bit_depth = 4'd0;
        in_valid = 1'b0;
        in_level = 16'sd0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_coef", out_coef, 0);
        check("rst_out_last", out_last, 0);
        check("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_tu(tbl[i]);
        end

        // Rejected configurations: one field out of range in each.
        do_cfg(8, 2, 0, 6, 1'b0);
        do_cfg(8, 1, 0, 0, 1'b0);
        do_cfg(8, 6, 0, 0, 1'b0);
        do_cfg(8, 2, 11, 0, 1'b0);
        do_cfg(7, 2, 0, 0, 1'b0);
        do_cfg(13, 2, 0, 0, 1'b0);

        // Reset in the middle of a TU with the pipeline full and stalled.
        do_cfg(8, 2, 0, 0, 1'b1);
        repeat (5) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_level  = 16'sd3;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_cfg_ready", cfg_ready, 1);
        check("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_level  = 16'sd99;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("idle_in_ready", in_ready, 0);
            check("idle_out_valid", out_valid, 0);
        end
        in_valid = 1'b0;
        run_tu(tbl[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
